// File: rtl/uart_tx_dev.sv
// ----------------------------------------------------------------------------
// uart_tx_dev
//   Memory-mapped 8N1 UART transmitter living in a timer-style bus slot.
//   The CPU pushes bytes into a small TX FIFO. A four-state serialiser drains
//   the FIFO onto txd, using a programmable number of clock cycles per bit.
//
// Ports
//   clk    in   1   system clock, all state on the rising edge
//   reset  in   1   asynchronous, active-high; clears all state
//   addr   in   2   word select: 0=CTRL 1=DIV 2=DATA 3=STATUS
//   we     in   1   write strobe, already qualified with the slot select
//   dataI  in  32   write data
//   dataO  out 32   read data, combinational from addr
//   irq    out  1   level interrupt: IE & FIFO empty & serialiser idle
//   txd    out  1   serial line, idle high, registered
//
// Register map
//   CTRL   [0] EN  transmit enable, [1] IE  interrupt enable
//   DIV    [15:0] cycles per bit (0 and 1 behave as 2)
//   DATA   write pushes dataI[7:0]; reads 0
//   STATUS [0] busy [1] full [2] empty [3] overflow (sticky) [8:4] count;
//          any write clears overflow
// ----------------------------------------------------------------------------
module uart_tx_dev #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] dataI,
  output logic [31:0] dataO,
  output logic        irq,
  output logic        txd
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DIV    = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_dev: FIFO_DEPTH must be a power of 2 in 2..16");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          en_q,     en_d;
  logic          ie_q,     ie_d;
  logic [15:0]   div_q,    div_d;
  logic          ovf_q,    ovf_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] rptr_q,   rptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic [1:0]    state_q,  state_d;
  logic [15:0]   baud_q,   baud_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    sh_q,     sh_d;
  logic          txd_q,    txd_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic wr_ctrl, wr_div, wr_data, wr_stat;

  assign wr_ctrl = we && (addr == A_CTRL);
  assign wr_div  = we && (addr == A_DIV);
  assign wr_data = we && (addr == A_DATA);
  assign wr_stat = we && (addr == A_STATUS);

  // Only the low half of the write bus is ever consumed.
  logic unused_data_hi;
  assign unused_data_hi = ^dataI[31:16];

  // --------------------------------------------------------------------------
  // FIFO flags and push/pop qualification
  // --------------------------------------------------------------------------
  logic        full, empty, busy;
  logic        tick, start_frame, pop, push_ok, push_drop;
  logic [15:0] div_eff;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

  // tick marks the last cycle of the current bit period.
  assign tick = busy && (baud_q == 16'd1);

  // A new frame is launched either from IDLE or straight out of a finishing
  // stop bit, so back-to-back bytes have no idle gap.
  assign start_frame = en_q && !empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));
  assign pop         = start_frame;

  // A push into a full FIFO is still accepted when a pop frees the slot on
  // the same edge; the read happens before the write overwrites that entry.
  assign push_ok   = wr_data && (!full || pop);
  assign push_drop = wr_data && full && !pop;

  // --------------------------------------------------------------------------
  // Register / FIFO next state
  // --------------------------------------------------------------------------
  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    div_d   = div_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (wr_ctrl) begin
      en_d = dataI[0];
      ie_d = dataI[1];
    end
    if (wr_div) begin
      div_d = dataI[15:0];
    end
    if (wr_stat) begin
      ovf_d = 1'b0;
    end else if (push_drop) begin
      ovf_d = 1'b1;
    end

    if (push_ok) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serialiser
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitidx_d = bitidx_q;
    sh_d     = sh_q;
    txd_d    = txd_q;

    if (busy && !tick) begin
      baud_d = baud_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          sh_d    = mem_q[rptr_q];
          baud_d  = div_eff;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          txd_d    = sh_q[0];
          sh_d     = {1'b0, sh_q[7:1]};
          bitidx_d = 3'd0;
          baud_d   = div_eff;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          // The divider is re-sampled at every bit boundary, so a DIV write
          // takes effect on the next bit while the current bit keeps its length.
          baud_d = div_eff;
          if (bitidx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            txd_d    = sh_q[0];
            sh_d     = {1'b0, sh_q[7:1]};
            bitidx_d = bitidx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (start_frame) begin
            sh_d    = mem_q[rptr_q];
            baud_d  = div_eff;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      div_q    <= 16'(DIV_RESET);
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitidx_q <= '0;
      sh_q     <= '0;
      txd_q    <= 1'b1;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitidx_q <= bitidx_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= dataI[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and outputs
  // --------------------------------------------------------------------------
  logic [4:0] count5;
  assign count5 = 5'(count_q);

  always_comb begin
    dataO = '0;
    case (addr)
      A_CTRL:   dataO = {30'd0, ie_q, en_q};
      A_DIV:    dataO = {16'd0, div_q};
      A_DATA:   dataO = '0;
      A_STATUS: dataO = {23'd0, count5, ovf_q, empty, full, busy};
      default:  dataO = '0;
    endcase
  end

  assign irq = ie_q && empty && !busy;
  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] dataI;
  logic [31:0] dataO;
  logic        irq;
  logic        txd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic txd_log [0:4095];
  logic irq_log [0:4095];

  uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(434)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .dataI (dataI),
    .dataO (dataO),
    .irq   (irq),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after rising edge n; outputs sampled 2ns in.
  always @(posedge clk) begin : mon
    int c;
    cyc = cyc + 1;
    c = cyc;
    #2;
    txd_log[c % 4096] = txd;
    irq_log[c % 4096] = irq;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected line level for cycle k (1-based) of a frame with constant divider.
  function automatic logic fbit(input logic [7:0] b, input int k, input int div);
    int s;
    s = (k - 1) / div;
    if (s == 0) return 1'b0;
    else if (s <= 8) return b[s-1];
    else return 1'b1;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    dataI = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dataO;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_txd got=%0h exp=1", txd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0h exp=0", irq); end
    rd(3, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL rst_status got=%0h exp=4", d); end
    rd(1, d);
    total++; if (d !== 32'd434) begin bad++; $display("FAIL rst_div got=%0d exp=434", d); end
    rd(0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%0h exp=0", d); end
    rd(2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_data_rd got=%0h exp=0", d); end
    @(negedge clk);
    reset = 1'b0;
    settle(2);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL post_rst_txd got=%0h exp=1", txd); end
    rd(3, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL post_rst_status got=%0h exp=4", d); end
  endtask

  task automatic test_single;
    int mark;
    logic e;
    wr(1, 32'd4);
    wr(0, 32'd1);
    wr(2, 32'h55);
    mark = cyc;
    addr = 2'd3;
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      e = (k <= 40);
      total++; if (dataO[0] !== e) begin bad++; $display("FAIL single_busy k=%0d got=%0h exp=%0h", k, dataO[0], e); end
    end
    #3;
    for (int k = 1; k <= 41; k++) begin
      e = (k <= 40) ? fbit(8'h55, k, 4) : 1'b1;
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL single_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int mark;
    logic e;
    wr(0, 32'd0);
    wr(2, 32'hA3);
    rd(3, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL b2b_cnt1 got=%0h exp=10", d); end
    wr(2, 32'h0F);
    rd(3, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL b2b_cnt2 got=%0h exp=20", d); end
    wr(0, 32'd1);
    mark = cyc;
    @(posedge clk); #1;
    rd(3, d);
    total++; if (d !== 32'h11) begin bad++; $display("FAIL b2b_cnt1b got=%0h exp=11", d); end
    repeat (39) @(posedge clk); #1;
    rd(3, d);
    total++; if (d !== 32'h11) begin bad++; $display("FAIL b2b_end1 got=%0h exp=11", d); end
    @(posedge clk); #1;
    rd(3, d);
    total++; if (d !== 32'h05) begin bad++; $display("FAIL b2b_cnt0 got=%0h exp=5", d); end
    repeat (39) @(posedge clk); #1;
    rd(3, d);
    total++; if (d !== 32'h05) begin bad++; $display("FAIL b2b_end2 got=%0h exp=5", d); end
    @(posedge clk); #1;
    rd(3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL b2b_idle got=%0h exp=4", d); end
    #3;
    for (int k = 1; k <= 81; k++) begin
      if (k <= 40) e = fbit(8'hA3, k, 4);
      else if (k <= 80) e = fbit(8'h0F, k - 40, 4);
      else e = 1'b1;
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL b2b_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int mark;
    logic e;
    logic [7:0] b;
    wr(0, 32'd0);
    for (int i = 1; i <= 5; i++) wr(2, i);
    rd(3, d);
    total++; if (d !== 32'h4A) begin bad++; $display("FAIL ovf_status got=%0h exp=4a", d); end
    rd(2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovf_data_rd got=%0h exp=0", d); end
    wr(3, 32'hFFFF_FFFF);
    rd(3, d);
    total++; if (d !== 32'h42) begin bad++; $display("FAIL ovf_clear got=%0h exp=42", d); end
    wr(0, 32'd1);
    mark = cyc;
    settle(170);
    for (int k = 1; k <= 170; k++) begin
      if (k <= 160) begin
        b = 8'((k - 1) / 40 + 1);
        e = fbit(b, k - ((k - 1) / 40) * 40, 4);
      end else begin
        e = 1'b1;
      end
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL ovf_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
    rd(3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL ovf_drained got=%0h exp=4", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int mark;
    logic e;
    wr(1, 32'hABCD_0002);
    rd(1, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL div_rd got=%0h exp=2", d); end
    wr(0, 32'hFFFF_FFFF);
    rd(0, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ctrl_rd got=%0h exp=3", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_idle got=%0h exp=1", irq); end
    wr(2, 32'hFF);
    mark = cyc;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_push got=%0h exp=0", irq); end
    settle(22);
    for (int k = 1; k <= 22; k++) begin
      e = (k >= 21);
      total++; if (irq_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL irq_frame k=%0d got=%0h exp=%0h", k, irq_log[(mark + k) % 4096], e); end
      e = fbit(8'hFF, k, 2);
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL irq_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
    // DIV=1 must behave as 2.
    wr(1, 32'd1);
    rd(1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL div1_rd got=%0h exp=1", d); end
    wr(2, 32'h00);
    mark = cyc;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_push2 got=%0h exp=0", irq); end
    settle(22);
    for (int k = 1; k <= 22; k++) begin
      e = (k >= 21);
      total++; if (irq_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL irq_frame2 k=%0d got=%0h exp=%0h", k, irq_log[(mark + k) % 4096], e); end
      e = fbit(8'h00, k, 2);
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL div1_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
    wr(0, 32'd1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_ie_clr got=%0h exp=0", irq); end
  endtask

  task automatic test_en_clear;
    logic [31:0] d;
    int mark;
    logic e;
    wr(1, 32'd4);
    wr(0, 32'd0);
    wr(2, 32'h3C);
    wr(2, 32'h5A);
    wr(2, 32'h81);
    wr(0, 32'd1);
    mark = cyc;
    repeat (11) @(posedge clk);
    wr(0, 32'd0);
    settle(48);
    for (int k = 1; k <= 60; k++) begin
      e = (k <= 40) ? fbit(8'h3C, k, 4) : 1'b1;
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL enclr_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
    rd(3, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL enclr_status got=%0h exp=20", d); end
  endtask

  task automatic test_div_change;
    logic [31:0] d;
    int mark;
    int s;
    logic e;
    logic [7:0] b;
    b = 8'h5A;
    wr(0, 32'd1);
    mark = cyc;
    repeat (17) @(posedge clk);
    wr(1, 32'd8);
    settle(124);
    for (int k = 1; k <= 142; k++) begin
      if (k <= 60) begin
        s = (k <= 20) ? (k - 1) / 4 : 5 + (k - 21) / 8;
        if (s == 0) e = 1'b0;
        else if (s <= 8) e = b[s-1];
        else e = 1'b1;
      end else if (k <= 140) begin
        e = fbit(8'h81, k - 60, 8);
      end else begin
        e = 1'b1;
      end
      total++; if (txd_log[(mark + k) % 4096] !== e) begin bad++; $display("FAIL divchg_txd k=%0d got=%0h exp=%0h", k, txd_log[(mark + k) % 4096], e); end
    end
    rd(3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL divchg_status got=%0h exp=4", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int mark;
    wr(1, 32'd4);
    wr(2, 32'h1F);
    wr(2, 32'hAA);
    wr(2, 32'hBB);
    rd(3, d);
    total++; if (d !== 32'h21) begin bad++; $display("FAIL rmid_queued got=%0h exp=21", d); end
    repeat (24) @(posedge clk);
    #3;
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rmid_bit5 got=%0h exp=0", txd); end
    reset = 1'b1;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rmid_txd got=%0h exp=1", txd); end
    rd(3, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL rmid_status got=%0h exp=4", d); end
    rd(1, d);
    total++; if (d !== 32'd434) begin bad++; $display("FAIL rmid_div got=%0d exp=434", d); end
    rd(0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rmid_irq got=%0h exp=0", irq); end
    @(negedge clk);
    reset = 1'b0;
    mark = cyc;
    settle(20);
    for (int k = 1; k <= 20; k++) begin
      total++; if (txd_log[(mark + k) % 4096] !== 1'b1) begin bad++; $display("FAIL rmid_idle k=%0d got=%0h exp=1", k, txd_log[(mark + k) % 4096]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    dataI = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_irq;
    test_en_clear;
    test_div_change;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
